// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX/MEM hazard inputs, stage-register controls and
// performance counters.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_jump;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             cnt_clr;
    logic             pc_write;
    logic [1:0]       if_id_option;
    logic [1:0]       id_ex_option;
    logic             ex_mem_hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_rt,
               ex_branch_taken, mem_busy, cnt_clr,
        input  pc_write, if_id_option, id_ex_option, ex_mem_hold, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_rt,
               ex_branch_taken, mem_busy, cnt_clr,
        output pc_write, if_id_option, id_ex_option, ex_mem_hold, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush, memory-wait freeze,
// with saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StLuStall = 2'b01,
        StMemWait = 2'b10
    } state_e;

    localparam logic [1:0] OptUpdate = 2'b00;
    localparam logic [1:0] OptFlush  = 2'b01;
    localparam logic [1:0] OptHold   = 2'b10;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu, lu_en, stall_inc, flush_inc;
    logic             pc_write;
    logic [1:0]       if_id_option, id_ex_option;
    logic             ex_mem_hold;

    always_comb begin
        lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
             ((bus.id_uses_rs && (bus.ex_rt == bus.id_rs)) ||
              (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
        // In LU_STALL the load has already moved to MEM, so the match is stale.
        lu_en = (state_q == StRun) || (state_q == StMemWait);

        pc_write     = 1'b1;
        if_id_option = OptUpdate;
        id_ex_option = OptUpdate;
        ex_mem_hold  = 1'b0;
        state_d      = StRun;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (bus.mem_busy) begin
            pc_write     = 1'b0;
            if_id_option = OptHold;
            id_ex_option = OptHold;
            ex_mem_hold  = 1'b1;
            state_d      = StMemWait;
            stall_inc    = 1'b1;
        end else if (bus.ex_branch_taken) begin
            if_id_option = OptFlush;
            id_ex_option = OptFlush;
            flush_inc    = 1'b1;
        end else if (lu && lu_en) begin
            pc_write     = 1'b0;
            if_id_option = OptHold;
            id_ex_option = OptFlush;
            state_d      = StLuStall;
            stall_inc    = 1'b1;
        end else if (bus.id_jump) begin
            if_id_option = OptFlush;
            flush_inc    = 1'b1;
        end

        // Encoding 11 is illegal; force a clean return to RUN.
        if (!(state_q inside {StRun, StLuStall, StMemWait})) begin
            state_d = StRun;
        end

        if (!reset) begin
            pc_write     = 1'b0;
            if_id_option = OptFlush;
            id_ex_option = OptFlush;
            ex_mem_hold  = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CntOne;
        end
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_option = if_id_option;
    assign bus.id_ex_option = id_ex_option;
    assign bus.ex_mem_hold  = ex_mem_hold;
    assign bus.state        = state_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule
